divider_arbiter: RTL and testbench
==================================

Name: divider_arbiter

Overview:
- Shares the single clock-divider instance between NREQ requesters (e.g. laser TX serializer, RX sampler, calibration sweep).
- Arbitrates round-robin, latches the winner's divide value and drives the divider's divider/en inputs.
- Holds enable low for a settle window after each reconfiguration, then signals ready until the owner releases.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DIV_W, 8, divider value width; matches the divider's divider input.
- SETTLE, 4, cycles div_en is held low after div_out changes (0 allowed).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; level, held until grant is released.
- req_div  in  NREQ x DIV_W  requested divider value per requester; sampled only at grant.
- done  in  NREQ  per-requester release pulse; only the granted bit is honoured.
- gnt  out  NREQ  one-hot grant.
- ready  out  1  divided clock is configured and running for the granted requester.
- div_out  out  DIV_W  to divider's divider input.
- div_en  out  1  to divider's en input.

Behaviour:
- Reset (async, reset=0):
  - gnt=0, ready=0, div_en=0, div_out=1.
  - State IDLE; round-robin pointer last=NREQ-1, so req[0] has first priority.
- IDLE:
  - If any req is high, choose the first set bit scanning from last+1 upward with wrap.
  - Latch idx and div_val = req_div[idx], with the value 0 clamped to 1. Go to LOAD.
  - With no request: outputs stay 0 and div_out holds its last value.
- LOAD (1 cycle):
  - gnt[idx]=1 and div_out=div_val; div_en=0, ready=0.
  - If SETTLE=0, go to RUN; otherwise load the settle counter with SETTLE-1 and go to SETTLE.
- SETTLE:
  - gnt held, div_en=0; counter decrements each cycle.
  - Go to RUN on the cycle the counter is 0, giving exactly SETTLE cycles in SETTLE.
- RUN:
  - gnt held; div_en=1 and ready=1.
  - Exit to DRAIN when done[idx]=1 or req[idx]=0.
- DRAIN (1 cycle):
  - gnt=0, ready=0, div_en=0; last<=idx. Then go to IDLE.
  - There is always at least 1 idle cycle between grants.
- Abort: req[idx] falling, or done[idx] pulsing, in LOAD or SETTLE goes to DRAIN next edge; ready is never asserted.
- Ignored inputs:
  - done bits of non-granted requesters are ignored in every state.
  - req_div changes during a grant are ignored; the latched value stands.
- Timing: with req[i] high before edge 0 in IDLE:
  - gnt valid after edge 0.
  - ready and div_en high after edge 1+SETTLE.
  - Release (done sampled at edge k) gives gnt=0 after edge k; the next grant is possible after edge k+2.
- Outputs are registered; gnt is one-hot or zero at all times.
- Reset mid-operation: immediate return to reset values and IDLE; last is reset too.

Decomposition:
- Package divider_arb_pkg:
  - state enum {IDLE, LOAD, SETTLE, RUN, DRAIN}.
  - Default DIV_W constant.
  - Localparam for the settle-counter width, $clog2(SETTLE+1).
- Sub-module rr_picker, combinational:
  - Inputs: req vector and last pointer.
  - Outputs: winner index and valid.
  - Instantiated once by the FSM.

Test Plan:
- Reset: hold reset=0 with req=2'b11 -> gnt=00, ready=0, div_en=0, div_out=1. Release -> gnt=01 after the first edge.
- Single grant, SETTLE=4, req[0]=1, req_div[0]=10:
  - gnt=01 and div_out=10 after edge 0.
  - div_en=ready=0 through edge 4; ready=div_en=1 after edge 5.
  - done[0] pulse -> gnt=00 next edge, IDLE after DRAIN.
- Round-robin, req=11 from reset, req_div[1]=6:
  - req[0] granted first.
  - After done[0] with req[0] still high, the next grant is gnt=10 with div_out=6.
  - After done[1], gnt=01 again.
- Zero clamp: req_div[1]=0 alone -> div_out=1 during the grant.
- Abort: drop req[0] during SETTLE -> DRAIN next edge; ready never 1; div_en stays 0. Pending req[1] is granted 2 edges later.
- Mid-run reset: assert reset in RUN -> gnt, ready and div_en go 0 immediately (asynchronous). After release with req=11, req[0] wins. A done[1] pulse while req[0] holds the grant has no effect.

Source files
------------

// File: rtl/divider_arb_pkg.sv
// divider_arb_pkg: state encoding and sizing helpers for the clock-divider arbiter.
// Rev 1.0
`default_nettype none

package divider_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } arb_state_e;

  localparam int DIV_W_DEF  = 8;
  localparam int SETTLE_DEF = 4;

  // Counter holds at most SETTLE-1; keep at least one bit so SETTLE=0 still elaborates.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

  localparam int SETTLE_CNT_W_DEF = settle_cnt_w(SETTLE_DEF);

endpackage

`default_nettype wire

// File: rtl/divider_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting just above the last owner.
// Rev 1.0
`default_nettype none

module rr_picker
  import divider_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  localparam logic [IDX_W:0] c_ONE    = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] c_NREQ_V = (IDX_W+1)'(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDX_W:0]    w_off;
  logic [IDX_W:0]    w_sum;
  logic [IDX_W:0]    w_wrap;

  // Rotate so bit 0 of w_rot is the requester right after the last owner.
  assign w_dbl = {req_i, req_i} >> ({1'b0, last_i} + c_ONE);
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_off   = '0;
    valid_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = i[IDX_W:0];
        valid_o = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, last_i} + w_off + c_ONE;
  assign w_wrap = w_sum - c_NREQ_V;
  assign idx_o  = (w_sum >= c_NREQ_V) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];

endmodule

`default_nettype wire

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin owner selection for the shared clock divider with settle window.
// Rev 1.0
`default_nettype none

module divider_arbiter
  import divider_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][DIV_W-1:0] req_div,
  input  logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            gnt,
  output logic                       ready,
  output logic [DIV_W-1:0]           div_out,
  output logic                       div_en
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = settle_cnt_w(SETTLE);

  localparam logic [CNT_W-1:0] c_CNT_INIT = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic [IDX_W-1:0] w_win;
  logic             w_win_vld;
  logic             w_rel;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (req),
    .last_i  (last_q),
    .idx_o   (w_win),
    .valid_o (w_win_vld)
  );

  // Only the owner's own done/req can end a grant.
  assign w_rel = done[idx_q] | ~req[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ready_d = ready_q;
    en_d    = en_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (w_win_vld) begin
          idx_d        = w_win;
          div_d        = (req_div[w_win] == '0) ? c_DIV_ONE : req_div[w_win];
          gnt_d        = '0;
          gnt_d[w_win] = 1'b1;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_rel) begin
          gnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (SETTLE == 0) begin
          ready_d = 1'b1;
          en_d    = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_d   = c_CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_rel) begin
          gnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (cnt_q == '0) begin
          ready_d = 1'b1;
          en_d    = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - c_CNT_ONE;
        end
      end
      ST_RUN: begin
        if (w_rel) begin
          gnt_d   = '0;
          ready_d = 1'b0;
          en_d    = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        last_d  = idx_q;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        ready_d = 1'b0;
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= c_LAST_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      div_q   <= c_DIV_ONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      div_q   <= div_d;
    end
  end

  assign gnt     = gnt_q;
  assign ready   = ready_q;
  assign div_en  = en_q;
  assign div_out = div_q;

endmodule

`default_nettype wire

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed plan steps plus random traffic against a grant-age reference model.
// Rev 1.0
`default_nettype none

module tb_divider_arbiter;

  localparam int NREQ   = 2;
  localparam int DIV_W  = 8;
  localparam int SETTLE = 4;

  logic                       CLOCK_50;
  logic                       reset;
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0][DIV_W-1:0] req_div;
  logic [NREQ-1:0]            done;
  logic [NREQ-1:0]            gnt;
  logic                       ready;
  logic [DIV_W-1:0]           div_out;
  logic                       div_en;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the divider, how many edges since the grant,
  // how many edges must pass before a new grant, and the round-robin memory.
  int              m_own;
  int              m_age;
  int              m_cool;
  int              m_last;
  logic [DIV_W-1:0] m_dout;

  divider_arbiter #(
    .NREQ   (NREQ),
    .DIV_W  (DIV_W),
    .SETTLE (SETTLE)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      (req),
    .req_div  (req_div),
    .done     (done),
    .gnt      (gnt),
    .ready    (ready),
    .div_out  (div_out),
    .div_en   (div_en)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic model_reset();
    m_own  = -1;
    m_age  = 0;
    m_cool = 0;
    m_last = NREQ - 1;
    m_dout = DIV_W'(1);
  endtask

  task automatic model_step();
    if (m_own >= 0) begin
      if (done[m_own] || !req[m_own]) begin
        m_last = m_own;
        m_own  = -1;
        m_cool = 1;
      end else begin
        m_age++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        int c;
        c = (m_last + off) % NREQ;
        if (m_own < 0 && req[c]) begin
          m_own  = c;
          m_age  = 0;
          m_dout = (req_div[c] == '0) ? DIV_W'(1) : req_div[c];
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [NREQ-1:0] eg;
    logic            er;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    er = (m_own >= 0) && (m_age >= 1 + SETTLE);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ready", 32'(ready), 32'(er));
    chk("div_en", 32'(div_en), 32'(er));
    chk("div_out", 32'(div_out), 32'(m_dout));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50);
      if (!reset) model_reset();
      else        model_step();
      @(negedge CLOCK_50);
      check_model();
    end
  endtask

  initial begin
    model_reset();
    reset   = 1'b0;
    req     = 2'b11;
    done    = '0;
    req_div[0] = 8'd10;
    req_div[1] = 8'd6;

    // Reset held with both requests pending
    cycle(3);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_div_out", 32'(div_out), 32'd1);

    // Release: req[0] first, then round-robin to req[1]
    reset = 1'b1;
    cycle();
    chk("first_gnt", 32'(gnt), 32'b01);
    chk("first_div", 32'(div_out), 32'd10);
    cycle(4);
    chk("settle_ready_low", 32'(ready), 32'd0);
    cycle();
    chk("ready_at_5", 32'(ready), 32'd1);
    cycle(2);
    done = 2'b01;
    cycle();
    done = '0;
    chk("release_gnt", 32'(gnt), 32'd0);
    cycle(2);
    chk("rr_gnt", 32'(gnt), 32'b10);
    chk("rr_div", 32'(div_out), 32'd6);
    cycle(6);
    done = 2'b10;
    cycle();
    done = '0;
    cycle(2);
    chk("rr_back_gnt", 32'(gnt), 32'b01);

    // Drop everything, then the zero-clamp case
    req = '0;
    cycle(3);
    req_div[1] = 8'd0;
    req = 2'b10;
    cycle();
    chk("clamp_div", 32'(div_out), 32'd1);
    cycle(7);
    req = '0;
    cycle(3);

    // Abort during settle with req[1] pending
    req_div[1] = 8'd6;
    req = 2'b01;
    cycle(3);
    req = 2'b10;
    cycle();
    chk("abort_gnt", 32'(gnt), 32'd0);
    cycle();
    cycle();
    chk("abort_next_gnt", 32'(gnt), 32'b10);

    // Mid-run reset
    cycle(6);
    chk("pre_rst_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_en", 32'(div_en), 32'd0);
    @(negedge CLOCK_50);
    req = 2'b11;
    cycle(2);
    reset = 1'b1;
    cycle();
    chk("post_rst_gnt", 32'(gnt), 32'b01);
    cycle(6);
    done = 2'b10;
    cycle(2);
    done = '0;
    chk("foreign_done_gnt", 32'(gnt), 32'b01);
    cycle(2);

    // Random traffic
    for (int t = 0; t < 600; t++) begin
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 7) == 0) req[r] = ~req[r];
        done[r] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0)
          req_div[r] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
